// File: rtl/booth_seq_mult.sv
// Purpose : iterative radix-2 Booth multiplier, signed WIDTH x WIDTH -> 2*WIDTH product.
// Latency : start accepted at edge E, done pulses in the cycle after edge E+WIDTH.
// Backpr. : one operation in flight; start is ignored unless ready is high.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   start                 request, accepted on an edge where ready=1
//   multiplicand          signed operand M, sampled on accept
//   multiplier            signed operand Q, sampled on accept
//   ready                 high in IDLE
//   busy                  high in RUN and DONE (always the complement of ready)
//   done                  registered one-cycle completion pulse
//   product               signed product, held until the next completion
module booth_seq_mult #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state;
  // A and Mx carry one guard bit so that M = -2^(WIDTH-1) negates without overflow.
  logic [WIDTH:0]   a;
  logic [WIDTH:0]   mx;
  logic [WIDTH-1:0] q;
  logic             q_1;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   a_sum;
  logic [WIDTH:0]   a_shift;
  logic [WIDTH-1:0] q_shift;

  // One Booth step: add/subtract selected by {Q[0],q_1}, then arithmetic
  // right shift of the concatenation {A,Q,q_1}.
  always_comb begin
    a_sum = a;
    case ({q[0], q_1})
      2'b01:   a_sum = a + mx;
      2'b10:   a_sum = a - mx;
      default: a_sum = a;
    endcase
    a_shift = {a_sum[WIDTH], a_sum[WIDTH:1]};
    q_shift = {a_sum[0], q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      a       <= '0;
      mx      <= '0;
      q       <= '0;
      q_1     <= 1'b0;
      cnt     <= '0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            a     <= '0;
            mx    <= {multiplicand[WIDTH-1], multiplicand};
            q     <= multiplier;
            q_1   <= 1'b0;
            cnt   <= CW'(WIDTH);
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          a   <= a_shift;
          q   <= q_shift;
          q_1 <= q[0];
          cnt <= cnt - CW'(1);
          // Last step: the guard bit of A is only sign extension, so the
          // low WIDTH bits of A together with Q form the full product.
          if (cnt == CW'(1)) begin
            product <= {a_shift[WIDTH-1:0], q_shift};
            done    <= 1'b1;
            state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ready = (state == ST_IDLE);
  assign busy  = ~ready;

endmodule

// File: tb/tb_booth_seq_mult.sv
// Purpose : self-checking bench for booth_seq_mult at WIDTH=8 and WIDTH=4.
// Latency : expects done in the cycle after edge E+WIDTH for an accept at edge E.
// Backpr. : drives start only when ready is expected; checks start is ignored while busy.
module tb_booth_seq_mult;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // WIDTH=8 instance
  logic        start8 = 1'b0;
  logic [7:0]  m8 = '0, q8 = '0;
  logic        ready8, busy8, done8;
  logic [15:0] prod8;

  booth_seq_mult #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8),
    .multiplicand(m8), .multiplier(q8),
    .ready(ready8), .busy(busy8), .done(done8), .product(prod8)
  );

  // WIDTH=4 instance
  logic        start4 = 1'b0;
  logic [3:0]  m4 = '0, q4 = '0;
  logic        ready4, busy4, done4;
  logic [7:0]  prod4;

  booth_seq_mult #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start4),
    .multiplicand(m4), .multiplier(q4),
    .ready(ready4), .busy(busy4), .done(done4), .product(prod4)
  );

  int checks = 0;
  int errors = 0;
  logic [15:0] last8 = '0;
  logic [7:0]  last4 = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain signed multiplication, truncated to the product width.
  function automatic logic [15:0] ref8(input logic [7:0] m, input logic [7:0] q);
    int p;
    p = int'($signed(m)) * int'($signed(q));
    return p[15:0];
  endfunction

  function automatic logic [7:0] ref4(input logic [3:0] m, input logic [3:0] q);
    int p;
    p = int'($signed(m)) * int'($signed(q));
    return p[7:0];
  endfunction

  // One WIDTH=8 transaction. With hold=1, start stays high and the operand
  // inputs are scrambled during RUN; the result must still use the first pair.
  task automatic op8(input logic [7:0] m, input logic [7:0] q, input logic [15:0] exp,
                     input bit hold, input string tag);
    int lat;
    lat = 0;
    @(negedge clk);
    chk({tag, "_ready"}, 32'(ready8), 32'd1);
    start8 = 1'b1; m8 = m; q8 = q;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 1) begin
        if (hold) begin m8 = ~m; q8 = ~q; end
        else start8 = 1'b0;
      end
      if (i == 4) begin
        chk({tag, "_prod_held"}, 32'(prod8), 32'(last8));
        chk({tag, "_busy"}, {30'd0, busy8, ready8}, 32'b10);
      end
      if (done8) begin lat = i; break; end
    end
    chk({tag, "_latency"}, 32'(lat), 32'd9);
    chk({tag, "_product"}, 32'(prod8), 32'(exp));
    last8 = exp;
    start8 = 1'b0;
    @(negedge clk);
    chk({tag, "_done_width"}, {30'd0, done8, ready8}, 32'b01);
  endtask

  task automatic op4(input logic [3:0] m, input logic [3:0] q, input logic [7:0] exp);
    int lat;
    lat = 0;
    @(negedge clk);
    start4 = 1'b1; m4 = m; q4 = q;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      start4 = 1'b0;
      if (done4) begin lat = i; break; end
    end
    chk("w4_latency", 32'(lat), 32'd5);
    chk($sformatf("w4_%0d_x_%0d", $signed(m), $signed(q)), 32'(prod4), 32'(exp));
    last4 = exp;
  endtask

  int ta[9] = '{3, -3, 5, -7, 0, -128, 127, -128, 127};
  int tb[9] = '{5, 5, -3, -9, -128, -128, -128, 127, 127};
  logic [15:0] te[9] = '{16'h000F, 16'hFFF1, 16'hFFF1, 16'h003F, 16'h0000,
                         16'h4000, 16'hC080, 16'hC080, 16'h3F01};
  logic [7:0] ba[3] = '{8'd11, 8'hCE, 8'd127};
  logic [7:0] bb[3] = '{8'hF4, 8'd33, 8'h80};

  initial begin
    logic [7:0] rm, rq;
    int dcyc[3];
    int seen;
    int off;
    logic [7:0] idx;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst8_flags", {29'd0, ready8, busy8, done8}, 32'b100);
    chk("rst8_product", 32'(prod8), 32'd0);
    chk("rst4_flags", {29'd0, ready4, busy4, done4}, 32'b100);
    chk("rst4_product", 32'(prod4), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle8_flags", {29'd0, ready8, busy8, done8}, 32'b100);

    // Directed sign and extreme-value table (first entry is 3 x 5)
    for (int k = 0; k < 9; k++) begin
      op8(8'(ta[k]), 8'(tb[k]), te[k], 1'b0, $sformatf("t8_%0d_x_%0d", ta[k], tb[k]));
      chk("t8_model_agrees", 32'(ref8(8'(ta[k]), 8'(tb[k]))), 32'(te[k]));
    end

    // Start held high with operands changing during RUN
    op8(8'd6, 8'd7, 16'h002A, 1'b1, "hold_6x7");
    @(negedge clk);
    chk("hold_no_reaccept", {30'd0, ready8, busy8}, 32'b10);

    // Asynchronous reset in the middle of RUN
    @(negedge clk);
    start8 = 1'b1; m8 = 8'd100; q8 = 8'd100;
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_busy", 32'(busy8), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_flags", {29'd0, ready8, busy8, done8}, 32'b100);
    chk("mid_rst_product", 32'(prod8), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    last8 = '0;
    last4 = '0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8) seen++;
    end
    chk("mid_rst_no_done", 32'(seen), 32'd0);
    op8(8'd2, 8'hFE, 16'hFFFC, 1'b0, "after_rst_2x-2");

    // Back-to-back with start tied high
    @(negedge clk);
    start8 = 1'b1; m8 = ba[0]; q8 = bb[0];
    for (int k = 0; k < 3; k++) begin
      dcyc[k] = -1000;
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        if (done8) begin dcyc[k] = cyc; break; end
      end
      chk($sformatf("b2b_%0d_product", k), 32'(prod8), 32'(ref8(ba[k], bb[k])));
      last8 = ref8(ba[k], bb[k]);
      if (k < 2) begin m8 = ba[k+1]; q8 = bb[k+1]; end
      else start8 = 1'b0;
    end
    chk("b2b_spacing_01", 32'(dcyc[1] - dcyc[0]), 32'd10);
    chk("b2b_spacing_12", 32'(dcyc[2] - dcyc[1]), 32'd10);
    @(negedge clk);

    // Random WIDTH=8 pairs
    for (int k = 0; k < 30; k++) begin
      rm = 8'($urandom);
      rq = 8'($urandom);
      op8(rm, rq, ref8(rm, rq), 1'b0, $sformatf("rnd8_%0d_x_%0d", $signed(rm), $signed(rq)));
    end

    // Exhaustive WIDTH=4 sweep starting at a random pair
    off = int'($urandom_range(0, 255));
    for (int i = 0; i < 256; i++) begin
      idx = 8'((i + off) % 256);
      op4(idx[7:4], idx[3:0], ref4(idx[7:4], idx[3:0]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
